// File: rtl/hrange_sum_pkg.sv
// Shared types and constants for the hrange_sum caller and its hrange generator callee.
package hrange_sum_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // A range yields nothing when it cannot advance or starts at/above its bound.
  function automatic logic range_empty(input logic signed [DATA_W-1:0] b,
                                       input logic signed [DATA_W-1:0] l,
                                       input logic signed [DATA_W-1:0] s);
    return (s <= 0) || (b >= l);
  endfunction

endpackage

// File: rtl/hrange_sum_hrange.sv
// hrange generator: yields base, base+step, ... while value < limit, one value per cycle.
module hrange_sum_hrange
  import hrange_sum_pkg::*;
(
  input  logic                     _clock,
  input  logic                     _reset,
  input  logic                     _start,
  input  logic signed [DATA_W-1:0] base,
  input  logic signed [DATA_W-1:0] limit,
  input  logic signed [DATA_W-1:0] step,
  output logic signed [DATA_W-1:0] _0,
  output logic                     _ready,
  output logic                     _valid
);

  logic                     run_q, run_d;
  logic signed [DATA_W-1:0] cur_q, cur_d;
  logic signed [DATA_W-1:0] lim_q, lim_d;
  logic signed [DATA_W-1:0] stp_q, stp_d;
  logic signed [DATA_W:0]   nxt;

  // NOTE: every variable gets a default before the branches so no latch is inferred.
  always_comb begin
    run_d = run_q;
    cur_d = cur_q;
    lim_d = lim_q;
    stp_d = stp_q;
    // One extra bit makes signed overflow compare above any limit and end the range.
    nxt   = {cur_q[DATA_W-1], cur_q} + {stp_q[DATA_W-1], stp_q};
    if (!run_q) begin
      if (_start) begin
        cur_d = base;
        lim_d = limit;
        stp_d = step;
        run_d = !range_empty(base, limit, step);
      end
    end else if (nxt >= $signed({lim_q[DATA_W-1], lim_q})) begin
      run_d = 1'b0;
    end else begin
      cur_d = nxt[DATA_W-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge _clock) begin
    if (_reset) begin
      run_q <= 1'b0;
      cur_q <= '0;
      lim_q <= '0;
      stp_q <= '0;
    end else begin
      run_q <= run_d;
      cur_q <= cur_d;
      lim_q <= lim_d;
      stp_q <= stp_d;
    end
  end

  assign _0     = cur_q;
  assign _valid = run_q;
  assign _ready = !run_q;

endmodule

// File: rtl/hrange_sum.sv
// Caller of one hrange generator: starts it, drains the yielded stream and reduces it to sum and count.
module hrange_sum
  import hrange_sum_pkg::*;
(
  input  logic                     _clock,
  input  logic                     _reset,
  input  logic                     _start,
  input  logic signed [DATA_W-1:0] base,
  input  logic signed [DATA_W-1:0] limit,
  input  logic signed [DATA_W-1:0] step,
  output logic signed [DATA_W-1:0] _0,
  output logic        [DATA_W-1:0] _1,
  output logic                     _ready,
  output logic                     _valid
);

  state_e                   state_q, state_d;
  logic signed [DATA_W-1:0] base_q, base_d;
  logic signed [DATA_W-1:0] limit_q, limit_d;
  logic signed [DATA_W-1:0] step_q, step_d;
  logic signed [DATA_W-1:0] sum_q, sum_d;
  logic        [DATA_W-1:0] cnt_q, cnt_d;

  logic                     callee_start;
  logic signed [DATA_W-1:0] callee_0;
  logic                     callee_ready;
  logic                     callee_valid;

  hrange_sum_hrange u_callee (
    ._clock (_clock),
    ._reset (_reset),
    ._start (callee_start),
    .base   (base_q),
    .limit  (limit_q),
    .step   (step_q),
    ._0     (callee_0),
    ._ready (callee_ready),
    ._valid (callee_valid)
  );

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    limit_d      = limit_q;
    step_d       = step_q;
    sum_d        = sum_q;
    cnt_d        = cnt_q;
    callee_start = 1'b0;
    _ready       = 1'b0;
    _valid       = 1'b0;

    if ((state_q == CALL || state_q == DRAIN) && callee_valid) begin
      sum_d = sum_q + callee_0;
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE, DONE: begin
        _ready  = 1'b1;
        _valid  = (state_q == DONE);
        state_d = IDLE;
        if (_start) begin
          base_d  = base;
          limit_d = limit;
          step_d  = step;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = range_empty(base, limit, step) ? DONE : CALL;
        end
      end
      CALL: begin
        callee_start = 1'b1;
        state_d      = DRAIN;
      end
      DRAIN: begin
        if (callee_ready) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge _clock) begin
    if (_reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      limit_q <= '0;
      step_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      limit_q <= limit_d;
      step_q  <= step_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
    end
  end

  assign _0 = sum_q;
  assign _1 = cnt_q;

endmodule

// File: doc/hrange_sum.md
HRANGE_SUM -- requirements
Module: hrange_sum

Interface
REQ-001 The block SHALL have one clock and one reset; the reset is synchronous and active-high.
REQ-002 Port: _clock  in  1  rising-edge clock.
REQ-003 Port: _reset  in  1  synchronous active-high reset.
REQ-004 Port: _start  in  1  one-cycle request; sampled only while _ready=1.
REQ-005 Port: base  in  32 signed  first range value, latched at accepted _start.
REQ-006 Port: limit  in  32 signed  exclusive upper bound, latched at accepted _start.
REQ-007 Port: step  in  32 signed  increment, latched at accepted _start.
REQ-008 Port: _0  out  32 signed  sum of all yielded values, modulo 2^32.
REQ-009 Port: _1  out  32 unsigned  count of yielded values.
REQ-010 Port: _ready  out  1  high when idle or done; low while a call is in flight.
REQ-011 Port: _valid  out  1  high for exactly one cycle when _0/_1 hold a fresh result.

Function
REQ-012 The block SHALL act as the caller/consumer of one hrange generator instance: it starts the generator, drains its yielded stream and reduces it to a sum and count.
REQ-013 The FSM SHALL have states IDLE, CALL, DRAIN and DONE.
REQ-014 IDLE: _ready=1, _valid=0; on _start=1 at edge S, latch inputs and clear the accumulators.
REQ-015 Empty range (step<=0 or base>=limit) SHALL short-circuit IDLE->DONE: the generator is not started and _0=0, _1=0.
REQ-016 Otherwise IDLE->CALL; in CALL (cycle S+1) the callee _start SHALL be driven 1 with the latched base/limit/step, then CALL->DRAIN.
REQ-017 In every CALL or DRAIN cycle with callee _valid=1, the block SHALL add callee _0 to the sum (32-bit wrap) and increment the count (32-bit wrap).
REQ-018 The block SHALL leave DRAIN for DONE in the first cycle after CALL with callee _ready=1; a callee _valid asserted in that same cycle SHALL still be accumulated.
REQ-019 DONE SHALL last one cycle with _ready=1 and _valid=1, then go to IDLE; the result SHALL be held on _0/_1 until the next accepted _start.
REQ-020 _start while _ready=0 SHALL be ignored; _start in DONE SHALL be accepted exactly as in IDLE.
REQ-021 Latency from accepted _start to _valid: 1 cycle for an empty range, otherwise N+3 cycles for N yielded values, with at most one value yielded per cycle.
REQ-022 Callee contract (hrange): yields base, base+step, ... while value<limit, one value per cycle with _valid=1; _ready=0 while running; next value computed at 33 bits so signed overflow terminates the range.

Reset
REQ-023 Reset SHALL force IDLE, _ready=1, _valid=0, _0=0, _1=0, and clear the latched inputs; the same reset SHALL be applied to the callee.
REQ-024 Reset asserted mid-call SHALL abandon the call with no _valid pulse; reset asserted together with _start SHALL take priority.

Structure
REQ-025 A shared package SHALL hold the FSM state enum and the 32-bit data width constant.
REQ-026 The block SHALL contain exactly one sub-module, the existing hrange generator, instantiated as the callee.

Verification
REQ-027 Start (0,10,2) -> yields 0,2,4,6,8; single _valid pulse with _0=20, _1=5, _ready=1.
REQ-028 Start (-4,4,3) -> _0=-3, _1=3.
REQ-029 Start (5,5,1), then (3,10,0) -> each gives _valid at S+1 with _0=0, _1=0; the callee _start never asserts.
REQ-030 Start (2147483600,2147483647,20) -> exactly 3 values; _0=2147483564, _1=3; no hang from overflow.
REQ-031 Start (0,100,1), assert _start again mid-run (ignored), then _reset at cycle S+20 -> no _valid pulse; IDLE with outputs 0; a following (0,10,2) call gives _0=20.
REQ-032 Results back to back: _start asserted in the DONE cycle of (0,10,2), with (1,4,1) -> second _valid with _0=6, _1=3.
